// File: rtl/accum_pkg.sv
// Shared types and widths for the 16-bit accumulator.
package accum_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_16bit.sv
// Unsigned 16-bit adder with carry-in; overflow is the carry-out of the MSB.
module adder_16bit
    import accum_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carry_in,
    output logic [DATA_W-1:0] sum,
    output logic              overflow
);

    logic [DATA_W:0] full_sum;

    // Widen by one bit so the carry-out falls out of the addition directly.
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, carry_in};
    end

    assign sum      = full_sum[DATA_W-1:0];
    assign overflow = full_sum[DATA_W];

endmodule

// File: rtl/accum_16bit.sv
// Counted accumulator: adds num_samples unsigned operands, then holds the
// result until the consumer takes it. Carry-out either clamps or wraps.
module accum_16bit
    import accum_pkg::*;
#(
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow_flag,
    output logic              busy
);

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic [DATA_W-1:0]   add_sum;
    logic                add_carry;
    logic                start_ok;
    logic                xfer;

    // Once the sum carries out, a saturating build pins the result at full
    // scale; FFFF plus any non-zero operand carries again, so it stays pinned.
    function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W-1:0] s,
                                                   input logic              c);
        if (c && (SATURATE != 0)) begin
            return {DATA_W{1'b1}};
        end
        return s;
    endfunction

    assign start_ok = (state_q == IDLE) && start;
    assign xfer     = (state_q == ACCUM) && in_valid;

    adder_16bit u_adder (
        .a        (acc_q),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_carry)
    );

    // Next-state decode: start only matters in IDLE, out_ready only in HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_samples == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid && (cnt_q <= 8'd1)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, remaining count and sticky overflow; a new run clears them,
    // otherwise they only move on an accepted operand and are held in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (start_ok) begin
            acc_q <= '0;
            cnt_q <= num_samples;
            ovf_q <= 1'b0;
        end else if (xfer) begin
            acc_q <= sat_sum(add_sum, add_carry);
            cnt_q <= cnt_q - 1'b1;
            ovf_q <= ovf_q | add_carry;
        end
    end

    // Handshake outputs are state decodes, forced low while reset is held so
    // no transfer is advertised in a cycle that reset will discard.
    assign in_ready      = (state_q == ACCUM) && !rst;
    assign out_valid     = (state_q == HOLD)  && !rst;
    assign busy          = (state_q != IDLE)  && !rst;
    assign acc_out       = acc_q;
    assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_accum_16bit.sv
// Randomized bench for accum_16bit: a saturating and a wrapping instance
// share stimulus and are compared against an arithmetic sum of each run.
module tb_accum_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_samples;
    logic [15:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_s, out_valid_s, ovf_s, busy_s;
    logic [15:0] acc_s;
    logic        in_ready_w, out_valid_w, ovf_w, busy_w;
    logic [15:0] acc_w;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] vals [0:255];

    always #5 clk = ~clk;

    accum_16bit #(.SATURATE(1)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_samples   (num_samples),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready_s),
        .acc_out       (acc_s),
        .out_valid     (out_valid_s),
        .out_ready     (out_ready),
        .overflow_flag (ovf_s),
        .busy          (busy_s)
    );

    accum_16bit #(.SATURATE(0)) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_samples   (num_samples),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready_w),
        .acc_out       (acc_w),
        .out_valid     (out_valid_w),
        .out_ready     (out_ready),
        .overflow_flag (ovf_w),
        .busy          (busy_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run: start, n operands (with stalls), hold_n backpressure
    // cycles, then release. Expected result is the plain integer sum.
    task automatic do_run(input int n, input int stall_fixed, input int hold_n,
                          input bit start_on_release);
        longint      total;
        logic        e_ovf;
        logic [15:0] e_sat;
        logic [15:0] e_wrap;
        int          st;

        total = 0;
        for (int i = 0; i < n; i++) total += vals[i];
        e_ovf  = (total > 65535);
        e_wrap = total[15:0];
        e_sat  = e_ovf ? 16'hFFFF : total[15:0];

        start       = 1'b1;
        num_samples = n[7:0];
        tick();
        start = 1'b0;
        check("busy_after_start", {busy_s, busy_w}, 2'b11);
        if (n > 0) begin
            check("accum_in_ready", {in_ready_s, in_ready_w}, 2'b11);
            check("accum_no_out_valid", {out_valid_s, out_valid_w}, 2'b00);
        end else begin
            check("zero_in_ready", {in_ready_s, in_ready_w}, 2'b00);
            check("zero_acc", {acc_s, acc_w}, 32'h0);
        end

        for (int i = 0; i < n; i++) begin
            st = (stall_fixed < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : stall_fixed);
            for (int k = 0; k < st; k++) begin
                in_valid    = 1'b0;
                in_data     = 16'($urandom);
                start       = 1'($urandom_range(0, 1));
                num_samples = 8'($urandom);
                out_ready   = 1'($urandom_range(0, 1));
                tick();
                start     = 1'b0;
                out_ready = 1'b0;
                check("stall_in_ready", {in_ready_s, in_ready_w}, 2'b11);
                check("stall_out_valid", {out_valid_s, out_valid_w}, 2'b00);
            end
            in_valid = 1'b1;
            in_data  = vals[i];
            tick();
            in_valid = 1'b0;
        end

        check("result_out_valid", {out_valid_s, out_valid_w}, 2'b11);
        check("result_in_ready", {in_ready_s, in_ready_w}, 2'b00);
        check("result_acc_sat", acc_s, e_sat);
        check("result_acc_wrap", acc_w, e_wrap);
        check("result_ovf", {ovf_s, ovf_w}, {e_ovf, e_ovf});

        for (int h = 0; h < hold_n; h++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(0, 1));
            in_valid  = 1'b1;
            in_data   = 16'($urandom);
            tick();
            start    = 1'b0;
            in_valid = 1'b0;
            check("hold_out_valid", {out_valid_s, out_valid_w}, 2'b11);
            check("hold_acc_sat", acc_s, e_sat);
            check("hold_acc_wrap", acc_w, e_wrap);
            check("hold_ovf", {ovf_s, ovf_w}, {e_ovf, e_ovf});
        end

        out_ready   = 1'b1;
        start       = start_on_release;
        num_samples = 8'd5;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("release_idle", {busy_s, out_valid_s, in_ready_s, busy_w, out_valid_w, in_ready_w}, 6'b0);
        check("idle_keep_acc_sat", acc_s, e_sat);
        check("idle_keep_acc_wrap", acc_w, e_wrap);
        check("idle_keep_ovf", {ovf_s, ovf_w}, {e_ovf, e_ovf});
        tick();
        check("idle_stays_idle", {busy_s, busy_w}, 2'b00);
        check("idle_hold_acc", acc_s, e_sat);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = 8'd0;
        in_data     = 16'd0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        tick();
        tick();
        check("reset_ctrl", {busy_s, out_valid_s, in_ready_s, busy_w, out_valid_w, in_ready_w}, 6'b0);
        check("reset_acc", {acc_s, acc_w}, 32'h0);
        check("reset_ovf", {ovf_s, ovf_w}, 2'b00);
        rst = 1'b0;
        tick();

        // Basic run 1+2+3.
        vals[0] = 16'h0001; vals[1] = 16'h0002; vals[2] = 16'h0003;
        do_run(3, 0, 0, 1'b0);

        // Carry-out: clamp vs wrap.
        vals[0] = 16'hFFF0; vals[1] = 16'h0020;
        do_run(2, 0, 1, 1'b0);

        // Further additions after saturation stay pinned.
        vals[0] = 16'hFFF0; vals[1] = 16'h0020; vals[2] = 16'h0005;
        do_run(3, 0, 0, 1'b0);

        // Stalls 1,0,0,1 and four cycles of backpressure.
        vals[0] = 16'h0005; vals[1] = 16'h0007;
        do_run(2, 2, 4, 1'b0);

        // Zero count goes straight to HOLD; start on release is not accepted.
        do_run(0, 0, 2, 1'b1);

        // Mid-run reset after one of three samples.
        start       = 1'b1;
        num_samples = 8'd3;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h0009;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("in_reset_ctrl", {busy_s, out_valid_s, in_ready_s}, 3'b0);
        tick();
        rst = 1'b0;
        check("midrun_reset_ctrl", {busy_s, out_valid_s, in_ready_s, busy_w}, 4'b0);
        check("midrun_reset_acc", {acc_s, acc_w}, 32'h0);
        check("midrun_reset_ovf", {ovf_s, ovf_w}, 2'b00);
        vals[0] = 16'h0004; vals[1] = 16'h0004; vals[2] = 16'h0004;
        do_run(3, 0, 0, 1'b0);

        // Random runs, operands biased toward large values to exercise carries.
        for (int r = 0; r < 40; r++) begin
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) begin
                vals[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hC000, 16'hFFFF))
                                                       : 16'($urandom_range(0, 16'h0FFF));
            end
            do_run(n, -1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/accum_16bit.md
ACCUM_16BIT -- requirements
Module: accum_16bit

Interface
- REQ-001 The block SHALL have parameter SATURATE, default 1, meaning: 1 clamps the accumulator at 16'hFFFF on carry-out; 0 lets it wrap modulo 2^16.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-004 The block SHALL have port start, input, 1 bit: begins a run; honoured only in IDLE.
- REQ-005 The block SHALL have port num_samples, input, 8 bits: sample count for the run; sampled when start is accepted.
- REQ-006 The block SHALL have port in_data, input, 16 bits: unsigned operand.
- REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
- REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
- REQ-009 The block SHALL have port acc_out, output, 16 bits: accumulated result.
- REQ-010 The block SHALL have port out_valid, output, 1 bit: acc_out is final.
- REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
- REQ-012 The block SHALL have port overflow_flag, output, 1 bit: sticky; a carry-out occurred during the run.
- REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
- REQ-014 The block SHALL implement FSM states IDLE, ACCUM and HOLD.
- REQ-015 In IDLE, start=1 with num_samples>0 SHALL clear the accumulator, clear overflow_flag, load the remaining count with num_samples, and go to ACCUM the next cycle.
- REQ-016 In IDLE, start=1 with num_samples=0 SHALL clear the accumulator and overflow_flag and go directly to HOLD, giving result 0.
- REQ-017 in_ready SHALL be 1 only in ACCUM; a transfer occurs when in_valid and in_ready are both 1.
- REQ-018 On each transfer, acc_out SHALL update next cycle to acc_out + in_data (carry_in=0), and the remaining count SHALL decrement.
- REQ-019 On a carry-out, overflow_flag SHALL set and stay set until the next accepted start or reset.
- REQ-020 On a carry-out with SATURATE=1, the accumulator SHALL load 16'hFFFF, and later additions SHALL keep it at 16'hFFFF.
- REQ-021 On a carry-out with SATURATE=0, the accumulator SHALL load the wrapped 16-bit sum.
- REQ-022 The transfer that brings the remaining count to 0 SHALL move the FSM to HOLD; out_valid SHALL be 1 the cycle after that final transfer (latency 1).
- REQ-023 In ACCUM, cycles with in_valid=0 SHALL leave all state unchanged; there is no timeout.
- REQ-024 In HOLD, out_valid=1, and acc_out and overflow_flag SHALL be stable until out_ready=1, at which point the FSM SHALL return to IDLE the next cycle.
- REQ-025 out_valid SHALL be 0 in IDLE and ACCUM.
- REQ-026 After a result is consumed, acc_out and overflow_flag SHALL keep their last values in IDLE.
- REQ-027 start SHALL be ignored in ACCUM and HOLD.
- REQ-028 out_ready SHALL be ignored outside HOLD.
- REQ-029 If start and out_ready are both 1 in HOLD, the block SHALL only return to IDLE; that start is not accepted.

Reset
- REQ-030 When rst=1 at a clock edge, state SHALL become IDLE, and acc_out, the remaining count and overflow_flag SHALL become 0.
- REQ-031 Reset SHALL take priority over all other inputs, including mid-run in ACCUM or HOLD; a partial result SHALL be discarded.
- REQ-032 While in reset: in_ready=0, out_valid=0, busy=0.

Structure
- REQ-033 Package accum_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD), DATA_W=16 and CNT_W=8.
- REQ-034 The addition SHALL use one instance of adder_16bit with carry_in tied to 0; its overflow output is the carry-out for REQ-019 to REQ-021.
- REQ-035 All other logic SHALL be in accum_16bit.
- REQ-036 Outputs SHALL be driven from registers or decoded from state only; there SHALL be no combinational path from in_data to acc_out.

Verification
- REQ-037 Basic run: start with num_samples=3, then inputs 16'h0001, 16'h0002, 16'h0003 on consecutive cycles -> out_valid=1 one cycle after the third transfer, acc_out=16'h0006, overflow_flag=0.
- REQ-038 Saturation (SATURATE=1): start with num_samples=2, inputs 16'hFFF0, 16'h0020 -> acc_out=16'hFFFF, overflow_flag=1.
- REQ-039 Wrap (SATURATE=0): same stimulus as REQ-038 -> acc_out=16'h0010, overflow_flag=1.
- REQ-040 Stalls and backpressure: in_valid toggles 1,0,0,1 with num_samples=2 (inputs 16'h0005, 16'h0007), and out_ready is held 0 for 4 cycles -> acc_out=16'h000C held stable with out_valid=1 throughout, then IDLE the cycle after out_ready=1.
- REQ-041 Zero count: start with num_samples=0 -> HOLD next cycle, acc_out=0, in_ready never asserts.
- REQ-042 Mid-run reset: rst=1 after 1 of 3 samples -> all outputs 0 / IDLE next cycle; a fresh run with 16'h0004 x3 then gives 16'h000C.
